// File: rtl/mp_pipe_core.sv
// Two-stage (decode/read, execute/write-back) register-file + ALU core; result valid one cycle after acceptance, backpressure stalls E then D.
// Macro MP_PIPE_FWD_EN: defined bypasses E.result into D on RAW hazards, undefined stalls D one bubble until write-back.
module mp_pipe_core #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int REG_N  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [ADDR_W-1:0] out_dst,
   output logic              out_err,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data
);
   localparam logic [5:0] OP_ABS   = 6'd1;
   localparam logic [5:0] OP_XOR   = 6'd4;
   localparam logic [5:0] OP_MINUS = 6'd5;
   localparam logic [5:0] OP_ADD   = 6'd6;
   localparam logic [5:0] OP_MAX   = 6'd7;
   localparam logic [5:0] OP_MIN   = 6'd8;
   localparam logic [5:0] OP_SUB   = 6'd9;
   localparam logic [5:0] OP_AVG   = 6'd11;
   localparam logic [5:0] OP_AND   = 6'd12;
   localparam logic [5:0] OP_OR    = 6'd13;
   localparam logic [5:0] OP_NOT   = 6'd14;

   logic [DATA_W-1:0] r_regs [REG_N];

   logic              r_d_full;
   logic [5:0]        r_d_op;
   logic [ADDR_W-1:0] r_d_src1;
   logic [ADDR_W-1:0] r_d_src2;
   logic [ADDR_W-1:0] r_d_dst;

   logic              r_e_full;
   logic              r_e_err;
   logic [DATA_W-1:0] r_e_result;
   logic [ADDR_W-1:0] r_e_dst;

   logic              w_e_drain;
   logic              w_hit1;
   logic              w_hit2;
   logic              w_stall;
   logic              w_d_adv;
   logic              w_accept;
   logic [DATA_W-1:0] w_a;
   logic [DATA_W-1:0] w_b;
   logic [DATA_W-1:0] w_alu;
   logic [DATA_W:0]   w_sum;
   logic              w_err;

   assign w_e_drain = r_e_full && out_ready;
   assign w_hit1    = r_e_full && !r_e_err && (r_d_src1 == r_e_dst);
   assign w_hit2    = r_e_full && !r_e_err && (r_d_src2 == r_e_dst);

`ifdef MP_PIPE_FWD_EN
   // D only advances into a full E when E drains, so a hit always sees the value being retired.
   assign w_stall = 1'b0;
   assign w_a     = w_hit1 ? r_e_result : r_regs[r_d_src1];
   assign w_b     = w_hit2 ? r_e_result : r_regs[r_d_src2];
`else
   assign w_stall = w_hit1 || w_hit2;
   assign w_a     = r_regs[r_d_src1];
   assign w_b     = r_regs[r_d_src2];
`endif

   assign w_d_adv  = r_d_full && (!r_e_full || w_e_drain) && !w_stall;
   assign in_ready = !r_d_full || w_d_adv;
   assign w_accept = in_valid && in_ready;

   assign out_valid  = r_e_full;
   assign out_result = r_e_result;
   assign out_dst    = r_e_dst;
   assign out_err    = r_e_err;

   always_comb begin
      w_alu = '0;
      w_err = 1'b0;
      w_sum = {1'b0, w_a} + {1'b0, w_b};
      case (r_d_op)
         OP_ADD:   w_alu = w_sum[DATA_W-1:0];
         OP_SUB:   w_alu = w_a - w_b;
         OP_ABS:   w_alu = w_a[DATA_W-1] ? ('0 - w_a) : w_a;
         OP_MINUS: w_alu = ~w_a + DATA_W'(1);
         OP_MAX:   w_alu = (w_a > w_b) ? w_a : w_b;
         OP_MIN:   w_alu = (w_a < w_b) ? w_a : w_b;
         OP_AVG:   w_alu = w_sum[DATA_W:1];
         OP_NOT:   w_alu = ~w_a;
         OP_OR:    w_alu = w_a | w_b;
         OP_AND:   w_alu = w_a & w_b;
         OP_XOR:   w_alu = w_a ^ w_b;
         default:  w_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_d_full <= 1'b0;
         r_d_op   <= '0;
         r_d_src1 <= '0;
         r_d_src2 <= '0;
         r_d_dst  <= '0;
      end else if (w_accept) begin
         r_d_full <= 1'b1;
         r_d_op   <= instr[5:0];
         r_d_src1 <= instr[6 +: ADDR_W];
         r_d_src2 <= instr[6+ADDR_W +: ADDR_W];
         r_d_dst  <= instr[6+2*ADDR_W +: ADDR_W];
      end else if (w_d_adv) begin
         r_d_full <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_e_full   <= 1'b0;
         r_e_err    <= 1'b0;
         r_e_result <= '0;
         r_e_dst    <= '0;
      end else if (w_d_adv) begin
         r_e_full   <= 1'b1;
         r_e_err    <= w_err;
         r_e_result <= w_err ? '0 : w_alu;
         r_e_dst    <= r_d_dst;
      end else if (w_e_drain) begin
         r_e_full   <= 1'b0;
      end
   end

   // Write-back is assigned last so it overrides a same-address external load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_N; i++) r_regs[i] <= '0;
      end else begin
         if (ld_en) r_regs[ld_addr] <= ld_data;
         if (w_e_drain && !r_e_err) r_regs[r_e_dst] <= r_e_result;
      end
   end
endmodule

// File: tb/tb_mp_pipe_core.sv
// Randomized and directed bench for mp_pipe_core against a program-order reference model.
module tb_mp_pipe_core;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int RN = 32;
`ifdef MP_PIPE_FWD_EN
   localparam int DEP_GAP = 1;
`else
   localparam int DEP_GAP = 2;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [31:0]   instr = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_result;
   logic [AW-1:0] out_dst;
   logic          out_err;
   logic          ld_en = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [DW-1:0] ld_data = '0;

   mp_pipe_core #(.DATA_W(DW), .ADDR_W(AW), .REG_N(RN)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_dst(out_dst), .out_err(out_err), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  dst;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mreg [32];
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          hs_edges[$];
   int          acc_edge = 0;
   logic        last_acc = 1'b0;
   logic [31:0] last_res = '0;
   logic        last_err = 1'b0;
   logic        p_hold = 1'b0;
   logic [31:0] p_res = '0;
   logic [4:0]  p_dst = '0;
   logic        p_err = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference ALU: {err, result}
   function automatic logic [32:0] ref_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      case (op)
         6'd6:    return {1'b0, a + b};
         6'd9:    return {1'b0, a - b};
         6'd1:    return {1'b0, a[31] ? (32'd0 - a) : a};
         6'd5:    return {1'b0, 32'd0 - a};
         6'd7:    return {1'b0, (a > b) ? a : b};
         6'd8:    return {1'b0, (a < b) ? a : b};
         6'd11:   return {1'b0, s[32:1]};
         6'd14:   return {1'b0, ~a};
         6'd13:   return {1'b0, a | b};
         6'd12:   return {1'b0, a & b};
         6'd4:    return {1'b0, a ^ b};
         default: return {1'b1, 32'd0};
      endcase
   endfunction

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
      logic [10:0] junk;
      junk = 11'($urandom());
      return {junk, d, s2, s1, op};
   endfunction

   // Instructions take effect in program order at acceptance; the pipeline must match that.
   task automatic model_issue(input logic [31:0] ins);
      logic [32:0] r;
      exp_t e;
      r = ref_alu(ins[5:0], mreg[ins[10:6]], mreg[ins[15:11]]);
      e.res = r[31:0];
      e.dst = ins[20:16];
      e.err = r[32];
      exp_q.push_back(e);
      if (!e.err) mreg[e.dst] = e.res;
   endtask

   task automatic step();
      logic        acc, hs, ld;
      logic [31:0] ins;
      logic [4:0]  la;
      logic [31:0] ldd;
      exp_t        e;
      @(negedge clk);
      if (p_hold) begin
         chk("hold_vld", out_valid, 1'b1);
         chk("hold_res", out_result, p_res);
         chk("hold_dst", out_dst, p_dst);
         chk("hold_err", out_err, p_err);
      end
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      ins = instr;
      ld  = ld_en;
      la  = ld_addr;
      ldd = ld_data;
      p_hold = out_valid && !out_ready;
      p_res  = out_result;
      p_dst  = out_dst;
      p_err  = out_err;
      if (hs) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out", out_result, 64'hDEAD_0000_0000);
         end else begin
            e = exp_q.pop_front();
            chk("res", out_result, e.res);
            chk("dst", out_dst, e.dst);
            chk("err", out_err, e.err);
         end
         last_res = out_result;
         last_err = out_err;
      end
      @(posedge clk);
      cyc++;
      if (hs) hs_edges.push_back(cyc);
      if (ld) mreg[la] = ldd;
      last_acc = acc;
      if (acc) begin
         model_issue(ins);
         acc_edge = cyc;
      end
      #1;
   endtask

   task automatic issue(input logic [5:0] op, input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
      int n;
      n = 0;
      instr = mk(op, s1, s2, d);
      in_valid = 1'b1;
      do begin
         step();
         n++;
      end while (!last_acc && n < 40);
      if (!last_acc) chk("issue_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && n < 60) begin
         step();
         n++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic load(input logic [4:0] a, input logic [31:0] d);
      ld_en = 1'b1;
      ld_addr = a;
      ld_data = d;
      step();
      ld_en = 1'b0;
   endtask

   task automatic readback(input string tag, input logic [4:0] r, input logic [31:0] exp);
      issue(6'd13, r, r, r);
      drain();
      chk(tag, last_res, exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] bp [3];
      logic [5:0]  ops [14];
      int          k;
      ops = '{6'd6, 6'd9, 6'd1, 6'd5, 6'd7, 6'd8, 6'd11, 6'd14, 6'd13, 6'd12, 6'd4, 6'd0, 6'd2, 6'd63};

      #1 rst = 1'b1;
      #10;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_result", out_result, 32'd0);
      chk("rst_out_dst", out_dst, 5'd0);
      chk("rst_out_err", out_err, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 32; i++) mreg[i] = '0;
      step();
      chk("rst_in_ready", in_ready, 1'b1);

      // Basic ADD; result visible one cycle after acceptance, so taken at the second edge.
      load(5'd1, 32'h1208);
      load(5'd2, 32'h2D78);
      hs_edges.delete();
      issue(6'd6, 5'd1, 5'd2, 5'd3);
      k = acc_edge;
      drain();
      chk("add_res", last_res, 32'h3F80);
      if (hs_edges.size() == 1) chk("add_latency", 64'(hs_edges[0] - k), 64'd2);
      else chk("add_out_count", 64'(hs_edges.size()), 64'd1);
      readback("add_rb", 5'd3, 32'h3F80);

      // Dependent pair back to back
      hs_edges.delete();
      issue(6'd6, 5'd1, 5'd2, 5'd3);
      issue(6'd9, 5'd3, 5'd1, 5'd4);
      drain();
      chk("dep_res", last_res, 32'h2D78);
      if (hs_edges.size() == 2) chk("dep_gap", 64'(hs_edges[1] - hs_edges[0]), 64'(DEP_GAP));
      else chk("dep_out_count", 64'(hs_edges.size()), 64'd2);

      // Invalid opcodes leave the destination alone
      load(5'd5, 32'h55);
      issue(6'd0, 5'd1, 5'd2, 5'd5);
      drain();
      chk("inv0_err", last_err, 1'b1);
      chk("inv0_res", last_res, 32'd0);
      issue(6'd15, 5'd1, 5'd2, 5'd5);
      drain();
      chk("inv15_err", last_err, 1'b1);
      chk("inv15_res", last_res, 32'd0);
      readback("inv_rb", 5'd5, 32'h55);

      // Backpressure: two accepted, third waits
      bp[0] = mk(6'd6, 5'd1, 5'd2, 5'd6);
      bp[1] = mk(6'd4, 5'd1, 5'd2, 5'd7);
      bp[2] = mk(6'd13, 5'd6, 5'd7, 5'd8);
      hs_edges.delete();
      out_ready = 1'b0;
      k = 0;
      for (int i = 0; i < 4; i++) begin
         instr = bp[k];
         in_valid = 1'b1;
         step();
         if (last_acc) k++;
      end
      chk("bp_accepted", 64'(k), 64'd2);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_no_output", 64'(hs_edges.size()), 64'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 10 && k < 3; i++) begin
         instr = bp[k];
         in_valid = 1'b1;
         step();
         if (last_acc) k++;
      end
      in_valid = 1'b0;
      drain();
      chk("bp_out_count", 64'(hs_edges.size()), 64'd3);
      chk("bp_last", last_res, 32'h3F80 | (32'h1208 ^ 32'h2D78));

      // AVG carry, unsigned MAX/MIN, ABS
      load(5'd1, 32'hFFFF_FFFF);
      load(5'd2, 32'hFFFF_FFFF);
      issue(6'd11, 5'd1, 5'd2, 5'd9);
      drain();
      chk("avg_carry", last_res, 32'hFFFF_FFFF);
      load(5'd1, 32'h8000_0000);
      load(5'd2, 32'd1);
      issue(6'd7, 5'd1, 5'd2, 5'd9);
      drain();
      chk("max_unsigned", last_res, 32'h8000_0000);
      issue(6'd8, 5'd1, 5'd2, 5'd9);
      drain();
      chk("min_unsigned", last_res, 32'd1);
      load(5'd1, 32'hFFFF_FFFE);
      issue(6'd1, 5'd1, 5'd0, 5'd9);
      drain();
      chk("abs_neg", last_res, 32'd2);

      // Random traffic on a small register window
      for (int i = 0; i < 8; i++) load(5'(i), $urandom());
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(9) < 7);
         instr = mk(ops[$urandom_range(13)], 5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)));
         step();
      end
      in_valid = 1'b0;
      drain();
      for (int i = 0; i < 8; i++) readback("rand_rb", 5'(i), mreg[i]);

      // Reset with both stages full
      load(5'd1, 32'd7);
      load(5'd2, 32'd9);
      out_ready = 1'b0;
      issue(6'd6, 5'd1, 5'd2, 5'd10);
      issue(6'd6, 5'd1, 5'd2, 5'd11);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valid", out_valid, 1'b0);
      chk("mid_rst_result", out_result, 32'd0);
      chk("mid_rst_err", out_err, 1'b0);
      exp_q.delete();
      for (int i = 0; i < 32; i++) mreg[i] = '0;
      p_hold = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 32; i++) readback("rst_reg_zero", 5'(i), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/mp_pipe_core.md
Name: mp_pipe_core

Overview:
- Parametrised, pipelined successor to the single-cycle register-file + ALU microprocessor datapath.
- Accepts one instruction per cycle over a valid/ready handshake. Executes it through a 2-stage pipeline: decode/read (D), then execute/write-back (E).
- Presents the result over an output valid/ready handshake and writes it back to the register file.
- Adds reset, backpressure, an external register load port, an invalid-opcode error flag, and read-after-write hazard handling.

Parameters:
- DATA_W, 32, register and ALU width.
- ADDR_W, 5, register address width; ADDR_W <= 8.
- REG_N, 32, number of registers; must equal 2**ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  core can accept an instruction.
- instr  in  32  instruction fields:
  - opcode = [5:0]
  - src1 = [6 +: ADDR_W]
  - src2 = [6+ADDR_W +: ADDR_W]
  - dst = [6+2*ADDR_W +: ADDR_W]
  - remaining bits ignored.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_result  out  DATA_W  ALU result.
- out_dst  out  ADDR_W  destination register of the result.
- out_err  out  1  result belongs to an invalid opcode.
- ld_en  in  1  external register write enable.
- ld_addr  in  ADDR_W  external write address.
- ld_data  in  DATA_W  external write data.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - D and E stages emptied; in-flight instructions are discarded with no write-back.
  - All registers cleared to 0.
  - out_valid=0, out_result=0, out_dst=0, out_err=0.
  - in_ready=1 from the first edge after rst deasserts.
- Opcodes (6-bit):
  - ADD=6: a+b.
  - SUB=9: a-b.
  - ABS=1: a[MSB] ? -a : a.
  - MINUS=5: ~a+1.
  - MAX=7 and MIN=8: unsigned compare.
  - AVG=11: (a+b)>>1, computed at DATA_W+1 bits so the carry is kept.
  - NOT=14: ~a.
  - OR=13, AND=12, XOR=4: bitwise.
  - All arithmetic wraps modulo 2**DATA_W.
  - Every other opcode is invalid.
- Stage D:
  - Captures the instruction when in_valid && in_ready.
  - in_ready = !D_full || d_adv.
- D advance condition: d_adv = D_full && (!E_full || e_drain) && !stall, where e_drain = E_full && out_ready.
- On d_adv:
  - Operands are read combinationally from the register file (with the bypass below).
  - The ALU is evaluated.
  - result, dst and err are registered into E.
- Stage E:
  - out_valid = E_full; E outputs are held stable while out_valid && !out_ready.
  - On e_drain with err=0: registers[dst] <= result at that edge.
  - With err=1: out_result=0 and no write-back.
- Latency: an instruction accepted at edge N has out_valid=1 after edge N+1 (one cycle after acceptance). Throughput is one instruction per cycle with no hazard and out_ready=1.
- Hazard: D reads src1 or src2 equal to E.dst while E_full && !E.err. Handling is set by FWD_EN (see Optional Feature).
- ld port:
  - Writes registers[ld_addr] <= ld_data at the edge.
  - If it collides with a same-address write-back in the same cycle, the write-back wins.
  - ld writes are not forwarded; software loads registers before issuing instructions that read them.
- in_valid is ignored while in_ready=0.
- instr must remain stable only at the accepting edge.

Optional Feature:
- Macro: MP_PIPE_FWD_EN.
- Defined:
  - stall=0.
  - When D advances on the same edge that E drains, a matching source operand takes E.result instead of the register file (E.dst to src bypass).
  - Dependent back-to-back instructions issue with no bubble.
- Undefined:
  - stall=1 while a hazard exists.
  - D advances once E has drained and the register is written: one bubble per dependent pair.
  - Results are identical in both builds; only timing differs.

Test Plan:
- Basic ADD: load R1=0x1208, R2=0x2D78; issue ADD src1=1, src2=2, dst=3 -> out_result=0x3F80 and out_dst=3 one cycle after acceptance; R3 reads back 0x3F80.
- Dependency chain: ADD R3=R1+R2, then SUB R4=R3-R1 on the next cycle -> second result=0x2D78.
  - With MP_PIPE_FWD_EN: results on consecutive cycles.
  - Without it: exactly one idle cycle between out_valid pulses.
- Invalid opcode: opcode=0, then opcode=15, with dst=5 -> out_err=1, out_result=0, R5 unchanged.
- Backpressure: hold out_ready=0 for 4 cycles with 3 instructions offered -> in_ready drops after 2 accepted, outputs stay stable, no write-back; release -> results in order, none lost or duplicated.
- AVG carry: R1=R2=0xFFFFFFFF -> AVG=0xFFFFFFFF; MAX/MIN of 0x80000000 and 1 -> 0x80000000 and 1; ABS of 0xFFFFFFFE -> 2.
- Reset mid-flight: assert rst with both stages full -> out_valid=0 immediately, all registers 0, no write-back of the discarded instructions.
